// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch pipeline.
package fetch_pkg;

  localparam int unsigned STAGES_MAX = 8;

  // Decoder NOP encodings; C8 is the default bubble word.
  localparam int unsigned NOP_C8 = 32'hC8;
  localparam int unsigned NOP_CF = 32'hCF;
  localparam int unsigned NOP_D8 = 32'hD8;
  localparam int unsigned NOP_DF = 32'hDF;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] addr;
    logic       valid;
  } stage_t;

  function automatic logic [3:0] popcount(input logic [STAGES_MAX-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < STAGES_MAX; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/fetch_pipe_if.sv
// Fetch-side and decoder-side signals of the fetch pipeline.
interface fetch_pipe_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic [DATA_W-1:0] pm_data;
  logic [ADDR_W-1:0] pm_addr;
  logic              fetch_valid;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_valid;

  modport slave (
    input  pm_data, pm_addr, fetch_valid, stall, flush,
    output instr_out, instr_addr, instr_valid
  );

  modport master (
    output pm_data, pm_addr, fetch_valid, stall, flush,
    input  instr_out, instr_addr, instr_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// One pipeline stage register: kill empties it, hold freezes it.
module fetch_stage #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       ADDR_W = 8,
  parameter logic [DATA_W-1:0] NOP_D  = '0
) (
  input  logic              clk,
  input  logic              sync_reset_n,
  input  logic              i_hold,
  input  logic              i_kill,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;

  // Kill outranks hold, so a flush during a stall still empties the stage.
  always_ff @(posedge clk) begin
    if (!sync_reset_n || i_kill) begin
      r_data  <= NOP_D;
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_data  <= i_data;
      r_addr  <= i_addr;
      r_valid <= i_valid;
    end
  end

  assign o_data  = r_data;
  assign o_addr  = r_addr;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_pipe.sv
// Configurable-depth fetch pipeline with stall, flush and saturating flush/squash counters.
module fetch_pipe
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned NOP_WORD = NOP_C8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              sync_reset_n,
  fetch_pipe_if.slave       bus,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  squash_count
);

  localparam logic [DATA_W-1:0] NOP_D = DATA_W'(NOP_WORD);
  localparam logic [CNT_W+3:0]  SAT   = {4'b0000, {CNT_W{1'b1}}};

  logic [DATA_W-1:0] w_q_data [STAGES];
  logic [ADDR_W-1:0] w_q_addr [STAGES];
  logic [STAGES-1:0] w_q_v;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [DATA_W-1:0] w_d;
    logic [ADDR_W-1:0] w_a;
    logic              w_v;

    if (k == 0) begin : g_head
      assign w_d = bus.pm_data;
      assign w_a = bus.pm_addr;
      assign w_v = bus.fetch_valid;
    end else begin : g_link
      assign w_d = w_q_data[k-1];
      assign w_a = w_q_addr[k-1];
      assign w_v = w_q_v[k-1];
    end

    fetch_stage #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NOP_D  (NOP_D)
    ) u_stage (
      .clk          (clk),
      .sync_reset_n (sync_reset_n),
      .i_hold       (bus.stall),
      .i_kill       (bus.flush),
      .i_data       (w_d),
      .i_addr       (w_a),
      .i_valid      (w_v),
      .o_data       (w_q_data[k]),
      .o_addr       (w_q_addr[k]),
      .o_valid      (w_q_v[k])
    );
  end

  assign bus.instr_valid = w_q_v[STAGES-1];
  assign bus.instr_out   = w_q_v[STAGES-1] ? w_q_data[STAGES-1] : NOP_D;
  assign bus.instr_addr  = w_q_v[STAGES-1] ? w_q_addr[STAGES-1] : '0;

  logic [STAGES_MAX-1:0] w_v_pad;
  logic [3:0]            w_pop;
  logic [CNT_W+3:0]      w_fc_sum;
  logic [CNT_W+3:0]      w_sc_sum;
  logic [CNT_W-1:0]      r_flush_cnt;
  logic [CNT_W-1:0]      r_squash_cnt;

  always_comb begin
    w_v_pad             = '0;
    w_v_pad[STAGES-1:0] = w_q_v;
  end

  assign w_pop    = popcount(w_v_pad);
  assign w_fc_sum = {4'b0000, r_flush_cnt} + (CNT_W+4)'(1);
  assign w_sc_sum = {4'b0000, r_squash_cnt} + {CNT_W'(0), w_pop};

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_flush_cnt  <= '0;
      r_squash_cnt <= '0;
    end else if (bus.flush) begin
      r_flush_cnt  <= (w_fc_sum > SAT) ? SAT[CNT_W-1:0] : w_fc_sum[CNT_W-1:0];
      r_squash_cnt <= (w_sc_sum > SAT) ? SAT[CNT_W-1:0] : w_sc_sum[CNT_W-1:0];
    end
  end

  assign flush_count  = r_flush_cnt;
  assign squash_count = r_squash_cnt;

endmodule
